// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore-style control FSM for a multicycle MIPS datapath. Each instruction
// walks FETCH -> DECODE -> (execute / memory / write-back) -> FETCH. Every
// datapath mux select and write enable is decoded from the state register.
// The one exception is pc_en in BRANCH, which follows the ALU zero flag.
//
// Ports
//   clock_i       rising-edge clock
//   reset_i       synchronous, active-high reset
//   op_i          IR[31:26]
//   funct_i       IR[5:0]
//   zero_i        ALU zero flag
//   alu_ctl_o     ALU code (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR)
//   alu_src_a_o   0 = PC, 1 = register A
//   alu_src_b_o   0 = B, 1 = 4, 2 = sext imm, 3 = sext imm << 2
//   pc_src_o      0 = ALU result, 1 = ALUOut, 2 = jump target
//   pc_en_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o  enables
//   i_or_d_o      memory address: 0 = PC, 1 = ALUOut
//   reg_dst_o     0 = rt, 1 = rd
//   mem_to_reg_o  0 = ALUOut, 1 = MDR
//   illegal_o     high while halted on an undecodable instruction
//   state_o       current state encoding (debug)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    output logic [3:0] alu_ctl_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_src_o,
    output logic       pc_en_o,
    output logic       ir_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       i_or_d_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_e state_q, state_d;

    // Raw (ungated) enables; reset masks them on the way out.
    logic pc_en_raw, ir_write_raw, mem_read_raw, mem_write_raw, reg_write_raw, illegal_raw;

    // R-type funct decode, shared by DECODE (legality) and R_EXEC (ALU code).
    logic       r_ok;
    logic [3:0] r_alu;

    always_comb begin
        r_ok  = 1'b1;
        r_alu = 4'd0;
        case (funct_i)
            6'h20:   r_alu = 4'd2;
            6'h22:   r_alu = 4'd6;
            6'h24:   r_alu = 4'd0;
            6'h25:   r_alu = 4'd1;
            6'h2A:   r_alu = 4'd7;
            6'h27:   r_alu = 4'd12;
            default: r_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        alu_ctl_o     = 4'd0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'd0;
        pc_src_o      = 2'd0;
        pc_en_raw     = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        i_or_d_o      = 1'b0;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                ir_write_raw = 1'b1;
                alu_src_b_o  = 2'd1;
                alu_ctl_o    = 4'd2;
                pc_en_raw    = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                alu_src_b_o = 2'd3;
                alu_ctl_o   = 4'd2;
                case (op_i)
                    OP_RTYPE:     state_d = r_ok ? S_R_EXEC : S_HALT;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_ctl_o   = 4'd2;
                state_d     = (op_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read_raw = 1'b1;
                i_or_d_o     = 1'b1;
                state_d      = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_raw = 1'b1;
                mem_to_reg_o  = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_raw = 1'b1;
                i_or_d_o      = 1'b1;
                state_d       = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_ctl_o   = r_alu;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_raw = 1'b1;
                reg_dst_o     = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                // A - B; take the target held in ALUOut when equal.
                alu_src_a_o = 1'b1;
                alu_ctl_o   = 4'd6;
                pc_src_o    = 2'd1;
                pc_en_raw   = zero_i;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src_o  = 2'd2;
                pc_en_raw = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_ctl_o   = 4'd2;
                state_d     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_HALT: begin
                illegal_raw = 1'b1;
                state_d     = S_HALT;
            end
            // Unused encodings 12-14 park in HALT.
            default: state_d = S_HALT;
        endcase
    end

    // No enable may fire while reset is held, whatever state is registered.
    assign pc_en_o     = pc_en_raw     & ~reset_i;
    assign ir_write_o  = ir_write_raw  & ~reset_i;
    assign mem_read_o  = mem_read_raw  & ~reset_i;
    assign mem_write_o = mem_write_raw & ~reset_i;
    assign reg_write_o = reg_write_raw & ~reset_i;
    assign illegal_o   = illegal_raw   & ~reset_i;
    assign state_o     = state_q;

endmodule
